ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit.
//   state_t   : FSM states of ex_muldiv
//   F3_*      : funct3 encodings of the RV32M operations
//   ITER_CNT  : number of radix-2 iterations per multiply/divide
package muldiv_pkg;

  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One 64-bit shift register and one 33-bit adder/subtractor are shared by
// shift-add multiply and restoring divide; operands are processed as
// magnitudes and the sign is fixed up when the result is presented.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           valid RV32M op in EX this cycle
//   funct3          operation select (MUL..REMU)
//   rs1_data        operand A (multiplicand / dividend)
//   rs2_data        operand B (multiplier / divisor)
//   cacheStall      global freeze
//   flush           abort current op, return to IDLE
//   busy            combinational stall request
//   done            result valid (DONE state)
//   result          rd write-back value, zero outside DONE
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        cacheStall,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2:0]         op_reg, op_next;
  // Multiply: {partial product hi, multiplier lo}. Divide: {remainder, quotient}.
  logic [63:0]        acc_reg, acc_next;
  logic [31:0]        opb_reg, opb_next;
  logic               neg_res_reg, neg_res_next;
  logic               neg_rem_reg, neg_rem_next;

  // Operand decode, only meaningful while accepting in IDLE.
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, div_ovf;

  always_comb begin
    a_signed    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                  (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg       = a_signed && rs1_data[31];
    b_neg       = b_signed && rs2_data[31];
    a_mag       = a_neg ? (~rs1_data + 32'd1) : rs1_data;
    b_mag       = b_neg ? (~rs2_data + 32'd1) : rs2_data;
    div_by_zero = is_div_op(funct3) && (rs2_data == 32'd0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  end

  // Shared 33-bit adder. Divide subtracts the divisor from the remainder
  // shifted left by one; the 33-bit sign bit is exact for that range, so it
  // doubles as the restoring-divide borrow.
  logic        is_mul;
  logic [32:0] add_a, add_b, sum;

  always_comb begin
    is_mul = !is_div_op(op_reg);
    add_a  = is_mul ? {1'b0, acc_reg[63:32]} : acc_reg[63:31];
    add_b  = is_mul ? {1'b0, opb_reg} : ~{1'b0, opb_reg};
    sum    = add_a + add_b + {32'd0, ~is_mul};
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    op_next      = op_reg;
    acc_next     = acc_reg;
    opb_next     = opb_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;

    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end else if (!cacheStall) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_next    = funct3;
            count_next = '0;
            if (div_by_zero) begin
              // Quotient all ones, remainder is the raw dividend.
              acc_next     = {rs1_data, 32'hFFFF_FFFF};
              opb_next     = '0;
              neg_res_next = 1'b0;
              neg_rem_next = 1'b0;
              state_next   = DONE;
            end else if (div_ovf) begin
              acc_next     = {32'd0, 32'h8000_0000};
              opb_next     = '0;
              neg_res_next = 1'b0;
              neg_rem_next = 1'b0;
              state_next   = DONE;
            end else begin
              acc_next     = {32'd0, a_mag};
              opb_next     = b_mag;
              neg_res_next = a_neg ^ b_neg;
              neg_rem_next = a_neg;
              state_next   = CALC;
            end
          end
        end
        CALC: begin
          if (is_mul) begin
            acc_next = acc_reg[0] ? {sum, acc_reg[31:1]} : {1'b0, acc_reg[63:1]};
          end else begin
            acc_next = sum[32] ? {acc_reg[62:0], 1'b0}
                               : {sum[31:0], acc_reg[30:0], 1'b1};
          end
          count_next = count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(ITER_CNT - 1)) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      op_reg      <= '0;
      acc_reg     <= '0;
      opb_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      op_reg      <= op_next;
      acc_reg     <= acc_next;
      opb_reg     <= opb_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
    end
  end

  // Sign fix-up and result selection from the frozen accumulator.
  logic [63:0] prod;
  logic [31:0] quot, rem, res_sel;

  always_comb begin
    prod = neg_res_reg ? (~acc_reg + 64'd1) : acc_reg;
    quot = neg_res_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    rem  = neg_rem_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    case (op_reg)
      F3_MUL:                       res_sel = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod[63:32];
      F3_DIV, F3_DIVU:              res_sel = quot;
      default:                      res_sel = rem;
    endcase
  end

  assign busy   = !rst && ((state_reg == CALC) || ((state_reg == IDLE) && start));
  assign done   = (state_reg == DONE);
  assign result = done ? res_sel : 32'd0;

endmodule
